// File: rtl/alu_rs_if.sv
// rv32i_types: ALU operation encoding shared by the station and its bench.
// alu_rs_if:   groups the dispatch, CDB snoop, issue and status signals of
//              the ALU reservation station.
//   slave  modport - the station itself
//   master modport - the dispatch/CDB/ALU environment driving the station
//   flush          - synchronous clear of every entry
//   dispatch_*     - valid/ready handshake carrying a new op and its operands
//   cdb_*          - common data bus broadcast (valid, tag, data)
//   issue_*        - valid/ready handshake presenting the oldest ready op
//   count          - number of occupied entries

package rv32i_types;
    typedef enum logic [2:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_ops;
endpackage

interface alu_rs_if #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 3
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  flush;

    logic                  dispatch_valid;
    logic                  dispatch_ready;
    rv32i_types::alu_ops   dispatch_aluop;
    logic [TAG_W-1:0]      dispatch_tag;
    logic [31:0]           dispatch_vj;
    logic [TAG_W-1:0]      dispatch_qj;
    logic                  dispatch_rj;
    logic [31:0]           dispatch_vk;
    logic [TAG_W-1:0]      dispatch_qk;
    logic                  dispatch_rk;

    logic                  cdb_valid;
    logic [TAG_W-1:0]      cdb_tag;
    logic [31:0]           cdb_data;

    logic                  issue_valid;
    logic                  issue_ready;
    rv32i_types::alu_ops   issue_aluop;
    logic [31:0]           issue_a;
    logic [31:0]           issue_b;
    logic [TAG_W-1:0]      issue_tag;

    logic [CNT_W-1:0]      count;

    modport slave (
        input  flush,
        input  dispatch_valid, dispatch_aluop, dispatch_tag,
        input  dispatch_vj, dispatch_qj, dispatch_rj,
        input  dispatch_vk, dispatch_qk, dispatch_rk,
        output dispatch_ready,
        input  cdb_valid, cdb_tag, cdb_data,
        output issue_valid, issue_aluop, issue_a, issue_b, issue_tag,
        input  issue_ready,
        output count
    );

    modport master (
        output flush,
        output dispatch_valid, dispatch_aluop, dispatch_tag,
        output dispatch_vj, dispatch_qj, dispatch_rj,
        output dispatch_vk, dispatch_qk, dispatch_rk,
        input  dispatch_ready,
        output cdb_valid, cdb_tag, cdb_data,
        input  issue_valid, issue_aluop, issue_a, issue_b, issue_tag,
        output issue_ready,
        input  count
    );
endinterface

// File: rtl/alu_rs.sv
// alu_rs: reservation station in front of the integer ALU.
// Collapsing queue of DEPTH entries; index 0 always holds the oldest op.
// Entries wait for missing operands by snooping the CDB and the oldest
// entry with both operands present is offered to the ALU.
//   clk  - clock
//   rst  - asynchronous, active-high reset
//   bus  - alu_rs_if.slave: flush, dispatch handshake, CDB snoop,
//          issue handshake and occupancy count

module alu_rs #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 3
) (
    input logic     clk,
    input logic     rst,
    alu_rs_if.slave bus
);
    import rv32i_types::*;

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic             valid;
        alu_ops           aluop;
        logic [TAG_W-1:0] tag;
        logic [31:0]      vj;
        logic [TAG_W-1:0] qj;
        logic             rj;
        logic [31:0]      vk;
        logic [TAG_W-1:0] qk;
        logic             rk;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic [DEPTH-1:0] ready;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    alu_ops           sel_aluop;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;
    logic [TAG_W-1:0] sel_tag;

    logic             issue_fire;
    logic             disp_fire;
    logic             disp_ready;
    int               wr_pos;

    // Readiness looks only at registered state, so a CDB wakeup becomes
    // visible to issue one cycle after the broadcast.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = ent_q[i].valid && ent_q[i].rj && ent_q[i].rk;
        end
    end

    // Scan from the top down so the lowest (oldest) ready index wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_aluop = alu_add;
        sel_a     = '0;
        sel_b     = '0;
        sel_tag   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_aluop = ent_q[i].aluop;
                sel_a     = ent_q[i].vj;
                sel_b     = ent_q[i].vk;
                sel_tag   = ent_q[i].tag;
            end
        end
    end

    // No credit for a same-cycle issue: ready depends on the stored count.
    assign disp_ready = (count_q < CNT_W'(DEPTH));
    assign issue_fire = sel_found && bus.issue_ready;
    assign disp_fire  = bus.dispatch_valid && disp_ready;

    // The new op goes into the first free slot after the collapse.
    assign wr_pos = int'(count_q) - (issue_fire ? 1 : 0);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
        end

        // Collapse: everything at or above the issued slot moves down one.
        if (issue_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i >= int'(sel_idx)) begin
                    if (i < DEPTH - 1) begin
                        ent_d[i] = ent_q[(i < DEPTH - 1) ? i + 1 : i];
                    end else begin
                        ent_d[i] = '0;
                    end
                end
            end
        end

        if (disp_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == wr_pos) begin
                    ent_d[i].valid = 1'b1;
                    ent_d[i].aluop = bus.dispatch_aluop;
                    ent_d[i].tag   = bus.dispatch_tag;
                    ent_d[i].vj    = bus.dispatch_vj;
                    ent_d[i].qj    = bus.dispatch_qj;
                    ent_d[i].rj    = bus.dispatch_rj;
                    ent_d[i].vk    = bus.dispatch_vk;
                    ent_d[i].qk    = bus.dispatch_qk;
                    ent_d[i].rk    = bus.dispatch_rk;
                end
            end
        end

        // Snoop after shift and write so the capture lands on each entry's
        // final slot; this also covers a freshly dispatched operand whose
        // producer broadcasts in the same cycle.
        if (bus.cdb_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_d[i].valid) begin
                    if (!ent_d[i].rj && (ent_d[i].qj == bus.cdb_tag)) begin
                        ent_d[i].vj = bus.cdb_data;
                        ent_d[i].rj = 1'b1;
                    end
                    if (!ent_d[i].rk && (ent_d[i].qk == bus.cdb_tag)) begin
                        ent_d[i].vk = bus.cdb_data;
                        ent_d[i].rk = 1'b1;
                    end
                end
            end
        end

        if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].valid = 1'b0;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (bus.flush) begin
            count_d = '0;
        end else if (disp_fire && !issue_fire) begin
            count_d = count_q + CNT_W'(1);
        end else if (!disp_fire && issue_fire) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            count_q <= count_d;
        end
    end

    assign bus.dispatch_ready = disp_ready;
    assign bus.issue_valid    = sel_found;
    assign bus.issue_aluop    = sel_aluop;
    assign bus.issue_a        = sel_a;
    assign bus.issue_b        = sel_b;
    assign bus.issue_tag      = sel_tag;
    assign bus.count          = count_q;

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: bench for the ALU reservation station. A queue model holds
// the ops in age order; a compare process checks the DUT against it on
// every falling edge, and directed scenarios pin literal expectations.

module tb_alu_rs;
    import rv32i_types::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    alu_rs_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

    alu_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       op;
        logic [TAG_W-1:0] tag;
        logic [31:0]      vj;
        logic [TAG_W-1:0] qj;
        bit               rj;
        logic [31:0]      vk;
        logic [TAG_W-1:0] qk;
        bit               rk;
    } m_ent_t;

    m_ent_t mq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_ready();
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].rj && mq[i].rk) return i;
        end
        return -1;
    endfunction

    // Reference model: remove issued op, append dispatched op, then wake.
    always @(posedge clk or posedge rst) begin
        int     s;
        bit     dsp;
        m_ent_t e;
        if (rst || bus.flush) begin
            mq.delete();
        end else begin
            s   = first_ready();
            dsp = bus.dispatch_valid && (mq.size() < DEPTH);
            if (s >= 0 && bus.issue_ready) mq.delete(s);
            if (dsp) begin
                e.op  = bus.dispatch_aluop;
                e.tag = bus.dispatch_tag;
                e.vj  = bus.dispatch_vj;
                e.qj  = bus.dispatch_qj;
                e.rj  = bus.dispatch_rj;
                e.vk  = bus.dispatch_vk;
                e.qk  = bus.dispatch_qk;
                e.rk  = bus.dispatch_rk;
                mq.push_back(e);
            end
            if (bus.cdb_valid) begin
                foreach (mq[i]) begin
                    if (!mq[i].rj && mq[i].qj == bus.cdb_tag) begin
                        mq[i].vj = bus.cdb_data;
                        mq[i].rj = 1'b1;
                    end
                    if (!mq[i].rk && mq[i].qk == bus.cdb_tag) begin
                        mq[i].vk = bus.cdb_data;
                        mq[i].rk = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        int s;
        if (!rst) begin
            s = first_ready();
            check("m_count", 32'(bus.count), 32'(mq.size()));
            check("m_dispatch_ready", 32'(bus.dispatch_ready), 32'(mq.size() < DEPTH));
            check("m_issue_valid", 32'(bus.issue_valid), 32'(s >= 0));
            if (s >= 0) begin
                check("m_issue_aluop", 32'(bus.issue_aluop), 32'(mq[s].op));
                check("m_issue_a", bus.issue_a, mq[s].vj);
                check("m_issue_b", bus.issue_b, mq[s].vk);
                check("m_issue_tag", 32'(bus.issue_tag), 32'(mq[s].tag));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.dispatch_valid = 1'b0;
        bus.cdb_valid      = 1'b0;
        bus.flush          = 1'b0;
    endtask

    task automatic disp(input alu_ops op, input int tag,
                        input logic [31:0] vj, input bit rj, input int qj,
                        input logic [31:0] vk, input bit rk, input int qk);
        bus.dispatch_valid = 1'b1;
        bus.dispatch_aluop = op;
        bus.dispatch_tag   = TAG_W'(tag);
        bus.dispatch_vj    = vj;
        bus.dispatch_rj    = rj;
        bus.dispatch_qj    = TAG_W'(qj);
        bus.dispatch_vk    = vk;
        bus.dispatch_rk    = rk;
        bus.dispatch_qk    = TAG_W'(qk);
    endtask

    task automatic cdb(input int tag, input logic [31:0] data);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = TAG_W'(tag);
        bus.cdb_data  = data;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        bus.issue_ready = 1'b0;
        disp(alu_add, 0, 0, 1'b0, 0, 0, 1'b0, 0);
        bus.dispatch_valid = 1'b0;
        bus.cdb_tag  = '0;
        bus.cdb_data = '0;
        repeat (2) @(negedge clk);
        check("rst_count", 32'(bus.count), 0);
        check("rst_issue_valid", 32'(bus.issue_valid), 0);
        check("rst_dispatch_ready", 32'(bus.dispatch_ready), 1);
        rst = 1'b0;
        @(negedge clk);

        // Single ready op goes straight through.
        bus.issue_ready = 1'b1;
        disp(alu_add, 1, 5, 1'b1, 0, 7, 1'b1, 0);
        tick();
        idle();
        check("t1_valid", 32'(bus.issue_valid), 1);
        check("t1_a", bus.issue_a, 5);
        check("t1_b", bus.issue_b, 7);
        check("t1_tag", 32'(bus.issue_tag), 1);
        check("t1_aluop", 32'(bus.issue_aluop), 32'(alu_add));
        tick();
        check("t1_count", 32'(bus.count), 0);

        // Wait on tag 3, wake by CDB, issue one cycle later.
        disp(alu_sub, 2, 0, 1'b0, 3, 1, 1'b1, 0);
        tick();
        idle();
        check("t2_wait0", 32'(bus.issue_valid), 0);
        tick();
        check("t2_wait1", 32'(bus.issue_valid), 0);
        cdb(3, 32'h10);
        tick();
        idle();
        check("t2_wake_valid", 32'(bus.issue_valid), 1);
        check("t2_wake_a", bus.issue_a, 32'h10);
        check("t2_wake_aluop", 32'(bus.issue_aluop), 32'(alu_sub));
        tick();
        check("t2_count", 32'(bus.count), 0);

        // Fill, overflow attempt, then drain in order.
        bus.issue_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            disp(alu_or, i, 32'(i * 10), 1'b1, 0, 32'(i), 1'b1, 0);
            tick();
        end
        check("t3_full_count", 32'(bus.count), 4);
        check("t3_full_ready", 32'(bus.dispatch_ready), 0);
        disp(alu_xor, 7, 32'hdead, 1'b1, 0, 0, 1'b1, 0);
        tick();
        idle();
        check("t3_ignored_count", 32'(bus.count), 4);
        check("t3_hold_tag", 32'(bus.issue_tag), 0);
        bus.issue_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("t3_order_tag", 32'(bus.issue_tag), 32'(i));
            check("t3_order_a", bus.issue_a, 32'(i * 10));
            tick();
        end
        check("t3_drained", 32'(bus.count), 0);

        // Younger ready entry bypasses two older waiting ones.
        bus.issue_ready = 1'b0;
        disp(alu_and, 4, 0, 1'b0, 2, 3, 1'b1, 0);
        tick();
        disp(alu_sll, 5, 7, 1'b1, 0, 0, 1'b0, 2);
        tick();
        disp(alu_srl, 6, 1, 1'b1, 0, 1, 1'b1, 0);
        tick();
        idle();
        check("t4_young_tag", 32'(bus.issue_tag), 6);
        bus.issue_ready = 1'b1;
        tick();
        check("t4_left_count", 32'(bus.count), 2);
        check("t4_none_ready", 32'(bus.issue_valid), 0);
        cdb(2, 32'h22);
        tick();
        idle();
        check("t4_e0_tag", 32'(bus.issue_tag), 4);
        check("t4_e0_a", bus.issue_a, 32'h22);
        check("t4_e0_b", bus.issue_b, 3);
        tick();
        check("t4_e1_tag", 32'(bus.issue_tag), 5);
        check("t4_e1_b", bus.issue_b, 32'h22);
        tick();
        check("t4_count", 32'(bus.count), 0);

        // Issue + dispatch + CDB on the same edge.
        bus.issue_ready = 1'b0;
        disp(alu_add, 1, 32'h100, 1'b1, 0, 1, 1'b1, 0);
        tick();
        disp(alu_add, 2, 32'h200, 1'b1, 0, 2, 1'b1, 0);
        tick();
        disp(alu_sra, 3, 9, 1'b1, 0, 0, 1'b0, 4);
        cdb(4, 32'hab);
        bus.issue_ready = 1'b1;
        tick();
        idle();
        check("t5_count", 32'(bus.count), 2);
        check("t5_head_tag", 32'(bus.issue_tag), 2);
        tick();
        check("t5_new_tag", 32'(bus.issue_tag), 3);
        check("t5_new_a", bus.issue_a, 9);
        check("t5_new_b", bus.issue_b, 32'hab);
        tick();
        check("t5_count_end", 32'(bus.count), 0);

        // Flush beats a simultaneous dispatch.
        bus.issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            disp(alu_add, i, 1, 1'b1, 0, 1, 1'b1, 0);
            tick();
        end
        check("t6_held", 32'(bus.count), 3);
        disp(alu_add, 5, 1, 1'b1, 0, 1, 1'b1, 0);
        bus.flush = 1'b1;
        tick();
        idle();
        check("t6_flush_count", 32'(bus.count), 0);
        check("t6_flush_valid", 32'(bus.issue_valid), 0);

        // Asynchronous reset between clock edges.
        for (int i = 0; i < 2; i++) begin
            disp(alu_add, i, 1, 1'b1, 0, 1, 1'b1, 0);
            tick();
        end
        idle();
        check("t7_pre_count", 32'(bus.count), 2);
        #2 rst = 1'b1;
        #1;
        check("t7_async_count", 32'(bus.count), 0);
        check("t7_async_valid", 32'(bus.issue_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Randomized traffic against the queue model.
        for (int n = 0; n < 3000; n++) begin
            bus.dispatch_valid = ($urandom_range(0, 99) < 55);
            bus.dispatch_aluop = alu_ops'($urandom_range(0, 7));
            bus.dispatch_tag   = TAG_W'($urandom_range(0, 7));
            bus.dispatch_vj    = $urandom;
            bus.dispatch_rj    = ($urandom_range(0, 99) < 50);
            bus.dispatch_qj    = TAG_W'($urandom_range(0, 7));
            bus.dispatch_vk    = $urandom;
            bus.dispatch_rk    = ($urandom_range(0, 99) < 50);
            bus.dispatch_qk    = TAG_W'($urandom_range(0, 7));
            bus.cdb_valid      = ($urandom_range(0, 99) < 40);
            bus.cdb_tag        = TAG_W'($urandom_range(0, 7));
            bus.cdb_data       = $urandom;
            bus.issue_ready    = ($urandom_range(0, 99) < 60);
            bus.flush          = ($urandom_range(0, 99) < 2);
            tick();
        end
        idle();
        bus.issue_ready = 1'b1;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station directly upstream of the integer ALU in the out-of-order core.
- Buffers dispatched ALU ops and snoops the common data bus (CDB) for missing source operands.
- Each cycle, presents the oldest fully-ready entry to the ALU as aluop/a/b plus its ROB tag.
- Collapsing queue: index 0 is always the oldest entry.

Parameters:
DEPTH, 4, number of station entries (≥2)
TAG_W, 3, ROB tag width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous clear of all entries (mispredict)
dispatch_valid  in  1  new op offered
dispatch_ready  out  1  station can accept
dispatch_aluop  in  alu_ops  operation (rv32i_types enum)
dispatch_tag  in  TAG_W  destination ROB tag
dispatch_vj  in  32  operand A value
dispatch_qj  in  TAG_W  producer tag for A
dispatch_rj  in  1  A value valid
dispatch_vk  in  32  operand B value
dispatch_qk  in  TAG_W  producer tag for B
dispatch_rk  in  1  B value valid
cdb_valid  in  1  broadcast valid
cdb_tag  in  TAG_W  broadcast tag
cdb_data  in  32  broadcast value
issue_valid  out  1  ready op presented to ALU
issue_ready  in  1  ALU/CDB path accepts op
issue_aluop  out  alu_ops  to ALU aluop
issue_a  out  32  to ALU a
issue_b  out  32  to ALU b
issue_tag  out  TAG_W  ROB tag travelling with result
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Per-entry state: valid, aluop, tag, vj/qj/rj, vk/qk/rk. Occupied entries are always contiguous at indices 0..count-1.
- Reset (asynchronous, rst=1):
  - All valid=0; count=0; issue_valid=0; dispatch_ready=1.
  - Other data outputs are don't-care; bench requires only issue_valid=0.
- Readiness: an entry is ready when valid && rj && rk, evaluated on registered state only.
  - A CDB wakeup in cycle N makes the entry issuable no earlier than cycle N+1.
  - No same-cycle CDB-to-issue bypass.
- Issue selection (combinational from registered state):
  - issue_valid=1 iff any entry is ready.
  - Selected entry = lowest-index ready entry.
  - issue_a=vj, issue_b=vk, issue_aluop/issue_tag come from that entry.
- Issue handshake:
  - The entry is consumed at the clock edge where issue_valid && issue_ready.
  - Entries above it shift down by one; count decrements.
  - When issue_ready=0, outputs hold (same entry stays selected unless an older entry became ready, which cannot happen without a wakeup edge).
- Dispatch:
  - dispatch_ready = (count < DEPTH), from registered count only; same-cycle issue gives no credit.
  - On dispatch_valid && dispatch_ready, the op is written at index count, or count-1 if an issue occurs the same edge.
  - dispatch_valid while !dispatch_ready is ignored; the station state is unchanged.
- CDB snoop, applied on every edge to every valid entry, including entries shifting down:
  - If cdb_valid && !rj && qj==cdb_tag, then vj<=cdb_data and rj<=1. Same rule for k.
  - Both operands may wake in the same cycle.
- Dispatch/CDB collision: if a dispatched operand has r=0 and q==cdb_tag with cdb_valid in the same cycle, the new entry stores cdb_data with r=1.
- Simultaneous issue + dispatch + CDB in one edge: all three apply. Shift, then write, with CDB capture applied to final positions. count is unchanged.
- Flush:
  - On an edge with flush=1, all valid<=0 and count<=0. Flush overrides dispatch and issue.
  - Any handshake occurring that cycle is discarded by the downstream side.
- rst asserted mid-operation clears immediately, regardless of clk.
- Invariant: count equals the number of valid entries, never exceeds DEPTH, and never underflows.

Test Plan:
- Reset, then dispatch alu_add with vj=5, vk=7, rj=rk=1, and issue_ready=1 → issue_valid=1 the next cycle with a=5, b=7, tag preserved; entry consumed, count returns to 0.
- Dispatch alu_sub with rj=0, qj=3. Hold 2 cycles → issue_valid=0. CDB tag=3 data=0x10 → issue_valid=1 exactly one cycle later with a=0x10.
- Fill 4 entries, all ready, with issue_ready=0 → dispatch_ready=0, count=4; a 5th dispatch is ignored. Raise issue_ready → entries issue in dispatch order, one per cycle.
- Entries 0 and 1 waiting on tag 2, entry 2 ready → entry 2 issues first. CDB tag 2 → entries 0 and 1 then issue, oldest first.
- Same cycle: dispatch with qk=4/rk=0, cdb tag=4 data=0xAB, and an issue of entry 0 → new entry lands at count-1 with b=0xAB ready; count unchanged.
- Three entries held, then flush=1 together with dispatch_valid=1 → count=0 and issue_valid=0 next cycle. Assert rst asynchronously mid-fill → count=0 and issue_valid=0 before the next clock edge.
